imem_port_arbiter: RTL and testbench

//  Shares the single synchronous port of the 1 KiB instruction memory between two requesters:
//  the core fetch stage (read-only) and the boot/debug loader (read/write). Owns the memory

---
 rtl/imem_arb_pkg.sv | 21 ++
 rtl/imem_addr_check.sv | 13 +
 rtl/imem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types for the instruction-memory port arbiter
package imem_arb_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH  = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    err;
        logic    we;
    } rsp_info_t;

endpackage

// File: rtl/imem_addr_check.sv
// rtl/imem_addr_check.sv - word alignment and range screen for memory requests
module imem_addr_check #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [31:0] addr,
    output logic        legal
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    assign legal = (addr[1:0] == 2'b00) && (addr <= LAST_WORD);

endmodule

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares the instruction memory port between core fetch and loader
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES  = 1024,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_done,
    input  logic        f_req_valid,
    input  logic [31:0] f_req_addr,
    output logic        f_req_ready,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        l_req_valid,
    input  logic        l_req_we,
    input  logic [31:0] l_req_addr,
    input  logic [31:0] l_req_wdata,
    output logic        l_req_ready,
    output logic        l_rsp_valid,
    output logic [31:0] l_rsp_data,
    output logic        l_rsp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned        CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    rsp_info_t        rsp_q, rsp_d;

    logic        f_grant, l_grant, any_grant;
    logic [31:0] sel_addr;
    logic        sel_legal;
    logic [31:0] rsp_data;

    always_comb begin
        state_d  = state_q;
        starve_d = '0;
        f_grant  = 1'b0;
        l_grant  = 1'b0;

        if (state_q == LOAD) begin
            l_grant = l_req_valid;
            if (boot_done) begin
                state_d = RUN;
            end
        end else begin
            // Loader wins unless fetch has already waited out STARVE_MAX loader grants.
            if (f_req_valid && (starve_q == STARVE_LIM)) begin
                f_grant = 1'b1;
            end else if (l_req_valid) begin
                l_grant = 1'b1;
            end else begin
                f_grant = f_req_valid;
            end

            if (f_req_valid && l_grant && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    assign any_grant = f_grant | l_grant;
    assign sel_addr  = f_grant ? f_req_addr : l_req_addr;

    imem_addr_check #(
        .MEM_BYTES(MEM_BYTES)
    ) u_addr_check (
        .addr (sel_addr),
        .legal(sel_legal)
    );

    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = any_grant;
        rsp_d.id    = f_grant ? REQ_FETCH : REQ_LOADER;
        rsp_d.err   = any_grant & ~sel_legal;
        rsp_d.we    = l_grant & l_req_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            starve_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rsp_q    <= rsp_d;
        end
    end

    assign f_req_ready = f_grant;
    assign l_req_ready = l_grant;

    assign mem_en    = any_grant & sel_legal;
    assign mem_we    = mem_en & l_grant & l_req_we;
    assign mem_addr  = mem_en ? sel_addr : 32'h0;
    assign mem_wdata = mem_we ? l_req_wdata : 32'h0;

    // Write acks and errored accesses return zero rather than whatever the memory last read.
    assign rsp_data = (rsp_q.valid && !rsp_q.err && !rsp_q.we) ? mem_rdata : 32'h0;

    assign f_rsp_valid = rsp_q.valid && (rsp_q.id == REQ_FETCH);
    assign f_rsp_data  = f_rsp_valid ? rsp_data : 32'h0;
    assign f_rsp_err   = f_rsp_valid & rsp_q.err;

    assign l_rsp_valid = rsp_q.valid && (rsp_q.id == REQ_LOADER);
    assign l_rsp_data  = l_rsp_valid ? rsp_data : 32'h0;
    assign l_rsp_err   = l_rsp_valid & rsp_q.err;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic        l_req_valid;
    logic        l_req_we;
    logic [31:0] l_req_addr;
    logic [31:0] l_req_wdata;
    logic        l_req_ready;
    logic        l_rsp_valid;
    logic [31:0] l_rsp_data;
    logic        l_rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:255];

    localparam bit          ILL_IS_F [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    localparam bit          ILL_WE   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] ILL_ADDR [4] = '{32'h12, 32'h400, 32'h3FC, 32'h401};
    localparam bit          ILL_EN   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit          ILL_ERR  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    localparam bit          ALT_IS_F [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    localparam bit          ALT_WE   [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam logic [31:0] ALT_ADDR [10] = '{32'h20, 32'h24, 32'h20, 32'h20, 32'h24,
                                             32'h24, 32'h24, 32'h20, 32'h20, 32'h24};
    localparam logic [31:0] ALT_WD   [10] = '{32'h11111111, 32'h22222222, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam logic [31:0] ALT_EXP  [10] = '{32'h0, 32'h0, 32'h11111111, 32'h11111111,
                                             32'h22222222, 32'h22222222, 32'h22222222,
                                             32'h11111111, 32'h11111111, 32'h22222222};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    imem_port_arbiter #(
        .MEM_BYTES (1024),
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boot_done  (boot_done),
        .f_req_valid(f_req_valid),
        .f_req_addr (f_req_addr),
        .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid),
        .f_rsp_data (f_rsp_data),
        .f_rsp_err  (f_rsp_err),
        .l_req_valid(l_req_valid),
        .l_req_we   (l_req_we),
        .l_req_addr (l_req_addr),
        .l_req_wdata(l_req_wdata),
        .l_req_ready(l_req_ready),
        .l_rsp_valid(l_rsp_valid),
        .l_rsp_data (l_rsp_data),
        .l_rsp_err  (l_rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic idle();
        boot_done   = 1'b0;
        f_req_valid = 1'b0;
        f_req_addr  = 32'h0;
        l_req_valid = 1'b0;
        l_req_we    = 1'b0;
        l_req_addr  = 32'h0;
        l_req_wdata = 32'h0;
    endtask

    task automatic drive(input bit is_f, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        idle();
        if (is_f) begin
            f_req_valid = 1'b1;
            f_req_addr  = addr;
        end else begin
            l_req_valid = 1'b1;
            l_req_we    = we;
            l_req_addr  = addr;
            l_req_wdata = wdata;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid, f_rsp_err, l_rsp_err, mem_en, mem_we} !== 8'h0) begin
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {f_req_ready, l_req_ready, f_rsp_valid, l_rsp_valid, f_rsp_err, l_rsp_err, mem_en, mem_we});
            n_fail++;
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, f_rsp_data, l_rsp_data} !== 128'h0) begin
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, f_rsp_data, l_rsp_data});
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_write();
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        f_req_valid = 1'b1;
        f_req_addr  = 32'h10;
        #1;
        n_cmp++;
        if ({l_req_ready, f_req_ready, mem_en, mem_we} !== 4'b1011) begin
            $display("FAIL load_grant: got %b expected 1011", {l_req_ready, f_req_ready, mem_en, mem_we});
            n_fail++;
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {32'h10, 32'hDEADBEEF}) begin
            $display("FAIL load_mem_bus: got %h expected %h", {mem_addr, mem_wdata}, {32'h10, 32'hDEADBEEF});
            n_fail++;
        end
        @(negedge clk);
        n_cmp++;
        if ({l_rsp_valid, l_rsp_err, f_rsp_valid, l_rsp_data} !== {3'b100, 32'h0}) begin
            $display("FAIL load_rsp: got %h expected %h", {l_rsp_valid, l_rsp_err, f_rsp_valid, l_rsp_data}, {3'b100, 32'h0});
            n_fail++;
        end
        l_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (f_req_ready !== 1'b0) begin
            $display("FAIL load_fetch_held: got %b expected 0", f_req_ready);
            n_fail++;
        end
        @(negedge clk);
        n_cmp++;
        if ({l_rsp_valid, f_rsp_valid} !== 2'b00) begin
            $display("FAIL load_rsp_single: got %b expected 00", {l_rsp_valid, f_rsp_valid});
            n_fail++;
        end
    endtask

    task automatic test_boot_fetch();
        // Loader read in the same cycle as boot_done, with fetch already waiting.
        drive(1'b0, 1'b0, 32'h10, 32'h0);
        boot_done   = 1'b1;
        f_req_valid = 1'b1;
        f_req_addr  = 32'h10;
        #1;
        n_cmp++;
        if ({l_req_ready, f_req_ready} !== 2'b10) begin
            $display("FAIL boot_grant: got %b expected 10", {l_req_ready, f_req_ready});
            n_fail++;
        end
        @(negedge clk);
        n_cmp++;
        if ({l_rsp_valid, l_rsp_err, f_rsp_valid, l_rsp_data} !== {3'b100, 32'hDEADBEEF}) begin
            $display("FAIL boot_l_rsp: got %h expected %h", {l_rsp_valid, l_rsp_err, f_rsp_valid, l_rsp_data}, {3'b100, 32'hDEADBEEF});
            n_fail++;
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        n_cmp++;
        if ({f_req_ready, l_req_ready, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h10}) begin
            $display("FAIL run_fetch_grant: got %h expected %h", {f_req_ready, l_req_ready, mem_en, mem_we, mem_addr}, {4'b1010, 32'h10});
            n_fail++;
        end
        @(negedge clk);
        n_cmp++;
        if ({f_rsp_valid, f_rsp_err, l_rsp_valid, f_rsp_data} !== {3'b100, 32'hDEADBEEF}) begin
            $display("FAIL run_fetch_rsp: got %h expected %h", {f_rsp_valid, f_rsp_err, l_rsp_valid, f_rsp_data}, {3'b100, 32'hDEADBEEF});
            n_fail++;
        end
        idle();
        boot_done = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({f_rsp_valid, l_rsp_valid} !== 2'b00) begin
            $display("FAIL run_rsp_single: got %b expected 00", {f_rsp_valid, l_rsp_valid});
            n_fail++;
        end
        idle();
    endtask

    task automatic test_illegal();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if ({f_rsp_valid, l_rsp_valid} !== {ILL_IS_F[i-1], !ILL_IS_F[i-1]}) begin
                    $display("FAIL ill_rsp_route[%0d]: got %b expected %b", i-1, {f_rsp_valid, l_rsp_valid}, {ILL_IS_F[i-1], !ILL_IS_F[i-1]});
                    n_fail++;
                end
                n_cmp++;
                if ({f_rsp_err | l_rsp_err, f_rsp_data, l_rsp_data} !== {ILL_ERR[i-1], 64'h0}) begin
                    $display("FAIL ill_rsp_err[%0d]: got %h expected %h", i-1, {f_rsp_err | l_rsp_err, f_rsp_data, l_rsp_data}, {ILL_ERR[i-1], 64'h0});
                    n_fail++;
                end
            end
            if (i < 4) begin
                drive(ILL_IS_F[i], ILL_WE[i], ILL_ADDR[i], 32'hCAFEF00D);
                #1;
                n_cmp++;
                if ({mem_en, mem_we, f_req_ready, l_req_ready} !== {ILL_EN[i], 1'b0, ILL_IS_F[i], !ILL_IS_F[i]}) begin
                    $display("FAIL ill_grant[%0d]: got %b expected %b", i, {mem_en, mem_we, f_req_ready, l_req_ready}, {ILL_EN[i], 1'b0, ILL_IS_F[i], !ILL_IS_F[i]});
                    n_fail++;
                end
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_starve();
        bit exp_f;
        bit prev_f;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if ({f_rsp_valid, l_rsp_valid, f_rsp_data | l_rsp_data} !== {prev_f, !prev_f, 32'hDEADBEEF}) begin
                    $display("FAIL starve_rsp[%0d]: got %h expected %h", i-1, {f_rsp_valid, l_rsp_valid, f_rsp_data | l_rsp_data}, {prev_f, !prev_f, 32'hDEADBEEF});
                    n_fail++;
                end
            end
            if (i < 10) begin
                idle();
                f_req_valid = 1'b1;
                f_req_addr  = 32'h10;
                l_req_valid = 1'b1;
                l_req_addr  = 32'h10;
                exp_f = ((i % 5) == 4);
                #1;
                n_cmp++;
                if ({f_req_ready, l_req_ready} !== {exp_f, !exp_f}) begin
                    $display("FAIL starve_grant[%0d]: got %b expected %b", i, {f_req_ready, l_req_ready}, {exp_f, !exp_f});
                    n_fail++;
                end
                prev_f = exp_f;
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_alternate();
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++;
                if ({f_rsp_valid, l_rsp_valid, f_rsp_err, l_rsp_err} !== {ALT_IS_F[i-1], !ALT_IS_F[i-1], 2'b00}) begin
                    $display("FAIL alt_rsp_route[%0d]: got %b expected %b", i-1, {f_rsp_valid, l_rsp_valid, f_rsp_err, l_rsp_err}, {ALT_IS_F[i-1], !ALT_IS_F[i-1], 2'b00});
                    n_fail++;
                end
                n_cmp++;
                if ((ALT_IS_F[i-1] ? f_rsp_data : l_rsp_data) !== ALT_EXP[i-1]) begin
                    $display("FAIL alt_rsp_data[%0d]: got %h expected %h", i-1, ALT_IS_F[i-1] ? f_rsp_data : l_rsp_data, ALT_EXP[i-1]);
                    n_fail++;
                end
            end
            if (i < 10) begin
                drive(ALT_IS_F[i], ALT_WE[i], ALT_ADDR[i], ALT_WD[i]);
                #1;
                n_cmp++;
                if ({f_req_ready, l_req_ready, mem_en} !== {ALT_IS_F[i], !ALT_IS_F[i], 1'b1}) begin
                    $display("FAIL alt_grant[%0d]: got %b expected %b", i, {f_req_ready, l_req_ready, mem_en}, {ALT_IS_F[i], !ALT_IS_F[i], 1'b1});
                    n_fail++;
                end
            end else begin
                idle();
            end
        end
    endtask

    task automatic test_reset_pending();
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({f_rsp_valid, l_rsp_valid, f_req_ready} !== 3'b000) begin
            $display("FAIL rst_pending_drop: got %b expected 000", {f_rsp_valid, l_rsp_valid, f_req_ready});
            n_fail++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({f_rsp_valid, l_rsp_valid, f_req_ready} !== 3'b000) begin
            $display("FAIL rst_back_to_load: got %b expected 000", {f_rsp_valid, l_rsp_valid, f_req_ready});
            n_fail++;
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_load_write();
        test_boot_fetch();
        test_illegal();
        test_starve();
        test_alternate();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
